// File: rtl/nn_acc_pkg.sv
// Shared constants for the NN accelerator back-end.
// FSM encodings and default datapath sizes.
package nn_acc_pkg;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_IDX_W       = 8;

endpackage

// File: rtl/nn_score_cmp.sv
// Combinational strict greater-than on two scores.
// Signedness fixed at elaboration time.
module nn_score_cmp #(
    parameter int DATA_W = 32,
    parameter int SIGNED = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
        end
    endgenerate

endmodule

// File: rtl/nn_output_argmax.sv
// Streaming argmax over one frame of output-neuron scores.
// Result is held behind a valid/ready handshake with frame-length checking.
module nn_output_argmax
    import nn_acc_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SIGNED      = 1,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              soft_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_class,
    output logic [DATA_W-1:0] out_score,
    output logic              out_len_err
);

    // One extra bit so the counter can hold NUM_CLASSES itself when it is 2^IDX_W.
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] NC = CNT_W'(NUM_CLASSES);

    logic [0:0]        state;
    logic [CNT_W-1:0]  count;
    logic              overrun;
    logic [DATA_W-1:0] best_score;
    logic [IDX_W-1:0]  best_idx;

    logic [DATA_W-1:0] nxt_score;
    logic [IDX_W-1:0]  nxt_idx;
    logic [CNT_W-1:0]  nxt_count;
    logic              nxt_len_err;
    logic              accept;
    logic              in_range;
    logic              gt;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign in_range  = (count < NC);

    nn_score_cmp #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a  (in_data),
        .b  (best_score),
        .gt (gt)
    );

    always_comb begin
        nxt_score = best_score;
        nxt_idx   = best_idx;
        if (count == '0) begin
            nxt_score = in_data;
            nxt_idx   = '0;
        end else if (in_range && gt) begin
            nxt_score = in_data;
            nxt_idx   = count[IDX_W-1:0];
        end
    end

    assign nxt_count   = in_range ? count + CNT_W'(1) : count;
    assign nxt_len_err = overrun || !in_range
                      || ((count + CNT_W'(1)) != NC);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= ST_ACCUM;
            count       <= '0;
            overrun     <= 1'b0;
            best_score  <= '0;
            best_idx    <= '0;
            out_class   <= '0;
            out_score   <= '0;
            out_len_err <= 1'b0;
        end else if (soft_clr) begin
            // Result registers keep their last values; only the frame is abandoned.
            state      <= ST_ACCUM;
            count      <= '0;
            overrun    <= 1'b0;
            best_score <= '0;
            best_idx   <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        best_score <= nxt_score;
                        best_idx   <= nxt_idx;
                        count      <= nxt_count;
                        overrun    <= overrun | ~in_range;
                        if (in_last) begin
                            state       <= ST_HOLD;
                            out_class   <= nxt_idx;
                            out_score   <= nxt_score;
                            out_len_err <= nxt_len_err;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state   <= ST_ACCUM;
                        count   <= '0;
                        overrun <= 1'b0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_output_argmax.sv
// Scoreboard bench: signed and unsigned instances share one stimulus stream.
// A behavioural argmax model predicts each frame result.
module tb_nn_output_argmax;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int IW = 8;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          soft_clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;

    logic          in_ready_s, out_valid_s, err_s;
    logic [IW-1:0] class_s;
    logic [DW-1:0] score_s;
    logic          in_ready_u, out_valid_u, err_u;
    logic [IW-1:0] class_u;
    logic [DW-1:0] score_u;

    nn_output_argmax #(
        .DATA_W(DW), .NUM_CLASSES(NC), .SIGNED(1), .IDX_W(IW)
    ) dut_s (
        .clock(clock), .rst(rst), .soft_clr(soft_clr),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_class(class_s), .out_score(score_s),
        .out_len_err(err_s)
    );

    nn_output_argmax #(
        .DATA_W(DW), .NUM_CLASSES(NC), .SIGNED(0), .IDX_W(IW)
    ) dut_u (
        .clock(clock), .rst(rst), .soft_clr(soft_clr),
        .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .out_class(class_u), .out_score(score_u),
        .out_len_err(err_u)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] cls_s;
        logic [DW-1:0] sc_s;
        logic          err_s;
        logic [IW-1:0] cls_u;
        logic [DW-1:0] sc_u;
        logic          err_u;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    logic pend_last = 1'b0;
    logic rnd_bp = 1'b0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: first maximum among the first NC beats; any length other than NC is an error.
    function automatic exp_t model(input logic [DW-1:0] v[$]);
        exp_t e;
        int n = v.size();
        int lim = (n < NC) ? n : NC;
        int bs = 0;
        int bu = 0;
        for (int i = 1; i < lim; i++) begin
            if ($signed(v[i]) > $signed(v[bs])) bs = i;
            if (v[i] > v[bu]) bu = i;
        end
        e.cls_s = IW'(bs);
        e.sc_s  = v[bs];
        e.err_s = (n != NC);
        e.cls_u = IW'(bu);
        e.sc_u  = v[bu];
        e.err_u = (n != NC);
        return e;
    endfunction

    always @(negedge clock) begin
        if (rst) begin
            pend_last = 1'b0;
        end else begin
            if (pend_last) begin
                chk("latency_s", 64'(out_valid_s), 64'd1);
                chk("latency_u", 64'(out_valid_u), 64'd1);
            end
            pend_last = in_valid && in_ready_s && in_last && !soft_clr;
            if (out_valid_s && out_ready && !soft_clr) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got class %0d expected none",
                             class_s);
                end else begin
                    mon_e = sb.pop_front();
                    chk("class_s", 64'(class_s), 64'(mon_e.cls_s));
                    chk("score_s", 64'(score_s), 64'(mon_e.sc_s));
                    chk("len_err_s", 64'(err_s), 64'(mon_e.err_s));
                    chk("valid_u", 64'(out_valid_u), 64'd1);
                    chk("class_u", 64'(class_u), 64'(mon_e.cls_u));
                    chk("score_u", 64'(score_u), 64'(mon_e.sc_u));
                    chk("len_err_u", 64'(err_u), 64'(mon_e.err_u));
                    chk("class_range", 64'(class_s < IW'(NC)), 64'd1);
                end
            end
        end
    end

    always @(posedge clock) begin
        if (rnd_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready_s && n < 200);
        if (!in_ready_s) begin
            checks++;
            fails++;
            $display("FAIL beat_timeout: got in_ready 0 expected 1");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] v[$], input bit push);
        if (push) sb.push_back(model(v));
        for (int i = 0; i < v.size(); i++)
            send_beat(v[i], i == v.size() - 1);
    endtask

    function automatic void to_vec(input int a[$], output logic [DW-1:0] v[$]);
        v = {};
        foreach (a[i]) v.push_back(DW'(a[i]));
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rand_frame(output logic [DW-1:0] v[$]);
        int len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : NC;
        int mode = $urandom_range(0, 2);
        v = {};
        for (int i = 0; i < len; i++) begin
            if (mode == 0)
                v.push_back(DW'($urandom));
            else if (mode == 1)
                v.push_back(DW'($urandom_range(0, 7)) - 32'd4);
            else
                v.push_back(32'h7FFF_FFFC + DW'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        logic [DW-1:0] v[$];
        int a[$];

        #1;
        chk("rst_in_ready", 64'(in_ready_s), 64'd1);
        chk("rst_out_valid", 64'({out_valid_s, out_valid_u}), 64'd0);
        chk("rst_class", 64'(class_s), 64'd0);
        chk("rst_score", 64'(score_s), 64'd0);
        chk("rst_len_err", 64'(err_s), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst = 1'b0;

        a = '{3, -7, 12, 12, 0, 5, -1, 9, 11, 2};
        to_vec(a, v);
        send_frame(v, 1);
        wait_idle();

        a = '{1, 2, 8, 4};
        to_vec(a, v);
        send_frame(v, 1);
        wait_idle();

        a = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 100};
        to_vec(a, v);
        send_frame(v, 1);
        wait_idle();

        a = '{-3};
        to_vec(a, v);
        send_frame(v, 1);
        wait_idle();

        // Backpressure with in_valid held high in HOLD.
        out_ready = 1'b0;
        rand_frame(v);
        send_frame(v, 1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'h7FFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("bp_in_ready", 64'(in_ready_s), 64'd0);
            chk("bp_out_valid", 64'(out_valid_s), 64'd1);
            chk("bp_class", 64'(class_s), 64'(sb[0].cls_s));
            chk("bp_score", 64'(score_s), 64'(sb[0].sc_s));
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("post_hs_valid", 64'(out_valid_s), 64'd0);
        chk("post_hs_ready", 64'(in_ready_s), 64'd1);
        a = '{4, 9, 1, 9, 2, 3, 0, 8, 7, 6};
        to_vec(a, v);
        @(posedge clock);
        #1;
        send_frame(v, 1);
        wait_idle();

        // soft_clr on beat 5 abandons the partial frame.
        a = '{1, 2, 3, 4, 5};
        to_vec(a, v);
        send_frame(v, 0);
        in_valid = 1'b1;
        in_data  = 32'h7FFF_FFFF;
        soft_clr = 1'b1;
        @(posedge clock);
        #1;
        soft_clr = 1'b0;
        in_valid = 1'b0;
        a = '{6, 2, 6, 1, 0, -9, 4, 3, 5, 2};
        to_vec(a, v);
        send_frame(v, 1);
        wait_idle();

        // soft_clr coincident with the result handshake discards the result.
        out_ready = 1'b0;
        a = '{0, 1, 2, 3, 4, 5, 6, 50, 8, 9};
        to_vec(a, v);
        send_frame(v, 1);
        @(posedge clock);
        #1;
        soft_clr  = 1'b1;
        out_ready = 1'b1;
        void'(sb.pop_back());
        @(posedge clock);
        #1;
        soft_clr = 1'b0;
        @(negedge clock);
        chk("clr_out_valid", 64'(out_valid_s), 64'd0);
        chk("clr_in_ready", 64'(in_ready_s), 64'd1);
        repeat (3) @(negedge clock);
        chk("clr_no_stale", 64'({out_valid_s, out_valid_u}), 64'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset mid-frame; held outputs still show class 7.
        a = '{1, 2, 3, 4};
        to_vec(a, v);
        send_frame(v, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_class", 64'(class_s), 64'd0);
        chk("arst_score", 64'(score_s), 64'd0);
        chk("arst_len_err", 64'(err_s), 64'd0);
        chk("arst_ready", 64'(in_ready_s), 64'd1);
        chk("arst_valid", 64'(out_valid_s), 64'd0);
        #2;
        rst = 1'b0;
        @(posedge clock);
        #1;
        a = '{-5, 1, 2, 3, 4, 5, 6, 7, 8, 90};
        to_vec(a, v);
        send_frame(v, 1);
        wait_idle();

        rnd_bp = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rand_frame(v);
            send_frame(v, 1);
        end
        rnd_bp = 1'b0;
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        wait_idle();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
